// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller, ALU and datapath:
// FSM states, opcode/funct values, ALU operation codes and mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BEQ,
        S_BGTZ,
        S_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    localparam logic [4:0] ALU_OP_ZERO = 5'd0;
    localparam logic [4:0] ALU_OP_ADD  = 5'd1;
    localparam logic [4:0] ALU_OP_SUB  = 5'd2;
    localparam logic [4:0] ALU_OP_AND  = 5'd3;
    localparam logic [4:0] ALU_OP_OR   = 5'd4;
    localparam logic [4:0] ALU_OP_XOR  = 5'd5;
    localparam logic [4:0] ALU_OP_NOR  = 5'd6;
    localparam logic [4:0] ALU_OP_BGTZ = 5'd7;

    localparam logic [1:0] ALU_SRC_B_REG  = 2'd0;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'd1;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'd2;
    localparam logic [1:0] ALU_SRC_B_BR   = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_alu_op_decode.sv
// Combinational opcode/funct decode: ALU operation, immediate extension mode and
// whether the instruction is supported at all.
module mc_alu_op_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] alu_op,
    output logic       imm_zext,
    output logic       legal
);

    always_comb begin
        alu_op   = ALU_OP_ZERO;
        imm_zext = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_OP_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_OP_SUB;
                    FN_AND:          alu_op = ALU_OP_AND;
                    FN_OR:           alu_op = ALU_OP_OR;
                    FN_XOR:          alu_op = ALU_OP_XOR;
                    FN_NOR:          alu_op = ALU_OP_NOR;
                    default:         legal  = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI, OP_ADDIU: alu_op = ALU_OP_ADD;
            OP_BEQ:  alu_op = ALU_OP_SUB;
            OP_BGTZ: alu_op = ALU_OP_BGTZ;
            OP_J:    alu_op = ALU_OP_ZERO;
            OP_ANDI: begin
                alu_op   = ALU_OP_AND;
                imm_zext = 1'b1;
            end
            OP_ORI: begin
                alu_op   = ALU_OP_OR;
                imm_zext = 1'b1;
            end
            OP_XORI: begin
                alu_op   = ALU_OP_XOR;
                imm_zext = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath
// enables, ALU op, memory-wait timeout and the retired-instruction counter.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             alu_flag,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             imm_zext,
    output logic [1:0]       pc_src,
    output logic [4:0]       alu_op,
    output logic             illegal_instr,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    // Counter only needs to reach WAIT_LIMIT-1; with WAIT_LIMIT=0 it just wraps unused.
    localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [4:0] dec_alu_op;
    logic       dec_imm_zext;
    logic       dec_legal;
    logic       mem_state;
    logic       timeout;
    logic       retire;

    mc_alu_op_decode u_alu_op_decode (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op   (dec_alu_op),
        .imm_zext (dec_imm_zext),
        .legal    (dec_legal)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);
    // mem_ready on the limit cycle completes normally, so it masks the timeout.
    assign timeout   = (WAIT_LIMIT != 0) && mem_state && !mem_ready &&
                       (wait_q == WAIT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_SRC_B_REG;
        imm_zext      = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_op        = ALU_OP_ZERO;
        illegal_instr = 1'b0;
        mem_err       = 1'b0;

        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_SRC_B_FOUR;
                alu_op    = ALU_OP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                mem_err   = timeout;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b     = ALU_SRC_B_BR;
                alu_op        = ALU_OP_ADD;
                illegal_instr = !dec_legal;
                if (!dec_legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:     state_d = S_R_EXEC;
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_BGTZ:      state_d = S_BGTZ;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_I_EXEC;
                    endcase
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_REG;
                alu_op    = dec_alu_op;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_IMM;
                alu_op    = dec_alu_op;
                imm_zext  = dec_imm_zext;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_IMM;
                alu_op    = ALU_OP_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                mem_err  = timeout;
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                mem_err   = timeout;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_REG;
                alu_op    = ALU_OP_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = alu_zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BGTZ: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_BGTZ;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = alu_flag;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    // Re-entering FETCH after a timeout is still an entry, so the counter clears then too.
    always_comb begin
        if ((state_d != state_q) || timeout) begin
            wait_d = '0;
        end else if (mem_state && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end
        count_d = retire ? (count_q + CNT_W'(1)) : count_q;
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: a per-cycle vector table plus hand-written
// sequences for memory waits, the wait timeout and asynchronous reset.
module tb_mc_control_fsm;

    typedef struct packed {
        logic pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
        logic alu_src_a;
        logic [1:0] alu_src_b;
        logic imm_zext;
        logic [1:0] pc_src;
        logic [4:0] alu_op;
        logic illegal_instr, mem_err;
    } out_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        f;
        logic        rdy;
        out_t        exp;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        out_t        exp;
        logic [31:0] cnt;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        alu_zero, alu_flag, mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
    logic        alu_src_a, imm_zext, illegal_instr, mem_err;
    logic [1:0]  alu_src_b, pc_src;
    logic [4:0]  alu_op;
    logic [31:0] instr_count;
    out_t        act;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   obs_mrd, obs_regw, obs_lat;

    mc_control_fsm #(.WAIT_LIMIT(16), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .alu_zero      (alu_zero),
        .alu_flag      (alu_flag),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_zext      (imm_zext),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr),
        .mem_err       (mem_err),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, imm_zext, pc_src, alu_op, illegal_instr, mem_err};

    // Expected per-state outputs, written straight from the controller description.
    function automatic out_t o_none();
        out_t o = '0;
        return o;
    endfunction
    function automatic out_t o_fetch(logic rdy, logic err);
        out_t o = '0;
        o.mem_read = 1; o.alu_src_b = 2'd1; o.alu_op = 5'd1;
        o.ir_write = rdy; o.pc_write = rdy; o.mem_err = err;
        return o;
    endfunction
    function automatic out_t o_decode(logic ill);
        out_t o = '0;
        o.alu_src_b = 2'd3; o.alu_op = 5'd1; o.illegal_instr = ill;
        return o;
    endfunction
    function automatic out_t o_rexec(logic [4:0] op);
        out_t o = '0;
        o.alu_src_a = 1; o.alu_op = op;
        return o;
    endfunction
    function automatic out_t o_rwb();
        out_t o = '0;
        o.reg_write = 1; o.reg_dst = 1;
        return o;
    endfunction
    function automatic out_t o_iexec(logic [4:0] op, logic zx);
        out_t o = '0;
        o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = op; o.imm_zext = zx;
        return o;
    endfunction
    function automatic out_t o_iwb();
        out_t o = '0;
        o.reg_write = 1;
        return o;
    endfunction
    function automatic out_t o_maddr();
        out_t o = '0;
        o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 5'd1;
        return o;
    endfunction
    function automatic out_t o_mread(logic err);
        out_t o = '0;
        o.mem_read = 1; o.iord = 1; o.mem_err = err;
        return o;
    endfunction
    function automatic out_t o_mwb();
        out_t o = '0;
        o.reg_write = 1; o.mem_to_reg = 1;
        return o;
    endfunction
    function automatic out_t o_mwrite(logic err);
        out_t o = '0;
        o.mem_write = 1; o.iord = 1; o.mem_err = err;
        return o;
    endfunction
    function automatic out_t o_beq(logic z);
        out_t o = '0;
        o.alu_src_a = 1; o.alu_op = 5'd2; o.pc_src = 2'd1; o.pc_write = z;
        return o;
    endfunction
    function automatic out_t o_bgtz(logic f);
        out_t o = '0;
        o.alu_src_a = 1; o.alu_op = 5'd7; o.pc_src = 2'd1; o.pc_write = f;
        return o;
    endfunction
    function automatic out_t o_jump();
        out_t o = '0;
        o.pc_src = 2'd2; o.pc_write = 1;
        return o;
    endfunction

    function automatic void add(string name, logic [5:0] op, logic [5:0] fn, logic z, logic f,
                                logic rdy, out_t e, logic [31:0] cnt);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.z = z; v.f = f; v.rdy = rdy;
        v.exp = e; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input out_t exp, input logic [31:0] cnt);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s outputs: got %h required %h", name, act, exp);
        end
        n_vec++;
        if (instr_count !== cnt) begin
            n_fail++;
            $display("FAIL %s instr_count: got %0d required %0d", name, instr_count, cnt);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, push the expectation, then
    // pop it and compare once outputs have settled, well before the next rising edge.
    task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic f, input logic rdy, input out_t e,
                        input logic [31:0] cnt);
        sb_t s;
        @(negedge clk);
        opcode = op; funct = fn; alu_zero = z; alu_flag = f; mem_ready = rdy;
        s.name = name; s.exp = e; s.cnt = cnt;
        sb_q.push_back(s);
        #1;
        s = sb_q.pop_front();
        check(s.name, s.exp, s.cnt);
        if (act.mem_read && act.iord) obs_mrd++;
        if (act.reg_write) obs_regw++;
        if (instr_count == 32'd0) obs_lat++;
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Leaves reset deasserted just after a rising edge so the next sample sees S_RESET.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 0; alu_flag = 0; mem_ready = 0;

        add("reset",      6'h00, 6'h20, 0, 0, 1, o_none(),            0);
        add("add_fetch",  6'h00, 6'h20, 0, 0, 1, o_fetch(1, 0),       0);
        add("add_dec",    6'h00, 6'h20, 0, 0, 1, o_decode(0),         0);
        add("add_exec",   6'h00, 6'h20, 0, 0, 1, o_rexec(5'd1),       0);
        add("add_wb",     6'h00, 6'h20, 0, 0, 1, o_rwb(),             0);
        add("sub_fetch",  6'h00, 6'h22, 0, 0, 1, o_fetch(1, 0),       1);
        add("sub_dec",    6'h00, 6'h22, 0, 0, 1, o_decode(0),         1);
        add("sub_exec",   6'h00, 6'h22, 0, 0, 1, o_rexec(5'd2),       1);
        add("sub_wb",     6'h00, 6'h22, 0, 0, 1, o_rwb(),             1);
        add("ori_fetch",  6'h0D, 6'h00, 0, 0, 1, o_fetch(1, 0),       2);
        add("ori_dec",    6'h0D, 6'h00, 0, 0, 1, o_decode(0),         2);
        add("ori_exec",   6'h0D, 6'h00, 0, 0, 1, o_iexec(5'd4, 1),    2);
        add("ori_wb",     6'h0D, 6'h00, 0, 0, 1, o_iwb(),             2);
        add("sw_fetch",   6'h2B, 6'h00, 0, 0, 1, o_fetch(1, 0),       3);
        add("sw_dec",     6'h2B, 6'h00, 0, 0, 1, o_decode(0),         3);
        add("sw_addr",    6'h2B, 6'h00, 0, 0, 1, o_maddr(),           3);
        add("sw_write",   6'h2B, 6'h00, 0, 0, 1, o_mwrite(0),         3);
        add("beq_fetch",  6'h04, 6'h00, 1, 0, 1, o_fetch(1, 0),       4);
        add("beq_dec",    6'h04, 6'h00, 1, 0, 1, o_decode(0),         4);
        add("beq_taken",  6'h04, 6'h00, 1, 0, 1, o_beq(1),            4);
        add("bgtz_fetch", 6'h07, 6'h00, 0, 0, 1, o_fetch(1, 0),       5);
        add("bgtz_dec",   6'h07, 6'h00, 0, 0, 1, o_decode(0),         5);
        add("bgtz_nt",    6'h07, 6'h00, 0, 0, 1, o_bgtz(0),           5);
        add("ill_fetch",  6'h3F, 6'h00, 0, 0, 1, o_fetch(1, 0),       6);
        add("ill_dec",    6'h3F, 6'h00, 0, 0, 1, o_decode(1),         6);
        add("j_fetch",    6'h02, 6'h00, 0, 0, 1, o_fetch(1, 0),       6);
        add("j_dec",      6'h02, 6'h00, 0, 0, 1, o_decode(0),         6);
        add("j_jump",     6'h02, 6'h00, 0, 0, 1, o_jump(),            6);
        add("illr_fetch", 6'h00, 6'h3F, 0, 0, 1, o_fetch(1, 0),       7);
        add("illr_dec",   6'h00, 6'h3F, 0, 0, 1, o_decode(1),         7);
        add("addi_fetch", 6'h08, 6'h00, 0, 0, 1, o_fetch(1, 0),       7);
        add("addi_dec",   6'h08, 6'h00, 0, 0, 1, o_decode(0),         7);
        add("addi_exec",  6'h08, 6'h00, 0, 0, 1, o_iexec(5'd1, 0),    7);
        add("addi_wb",    6'h08, 6'h00, 0, 0, 1, o_iwb(),             7);
        add("sw2_fetch",  6'h2B, 6'h00, 0, 0, 1, o_fetch(1, 0),       8);

        do_reset();
        foreach (tbl[i])
            step(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].f, tbl[i].rdy,
                 tbl[i].exp, tbl[i].cnt);

        // sw stalled in MEM_WRITE, then reset mid-access: outputs must drop before any edge.
        step("sw2_dec",   6'h2B, 6'h00, 0, 0, 1, o_decode(0), 8);
        step("sw2_addr",  6'h2B, 6'h00, 0, 0, 0, o_maddr(),   8);
        step("sw2_wait",  6'h2B, 6'h00, 0, 0, 0, o_mwrite(0), 8);
        #1 rst_n = 1'b0;
        #1 check("async_rst", o_none(), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step("rst_again", 6'h23, 6'h00, 0, 0, 1, o_none(), 0);

        // lw with three wait cycles in MEM_READ.
        obs_mrd = 0; obs_regw = 0; obs_lat = 0;
        step("lw_fetch",  6'h23, 6'h00, 0, 0, 1, o_fetch(1, 0), 0);
        step("lw_dec",    6'h23, 6'h00, 0, 0, 1, o_decode(0),   0);
        step("lw_addr",   6'h23, 6'h00, 0, 0, 0, o_maddr(),     0);
        for (int i = 0; i < 3; i++)
            step("lw_wait", 6'h23, 6'h00, 0, 0, 0, o_mread(0), 0);
        step("lw_done",   6'h23, 6'h00, 0, 0, 1, o_mread(0),    0);
        step("lw_wb",     6'h23, 6'h00, 0, 0, 0, o_mwb(),       0);
        check_int("lw_mread_iord_cycles", obs_mrd, 4);
        check_int("lw_reg_write_cycles", obs_regw, 1);
        check_int("lw_latency", obs_lat, 8);

        // FETCH starved of mem_ready: mem_err on the 16th cycle, then a clean re-fetch.
        for (int i = 0; i < 15; i++)
            step("to_wait", 6'h02, 6'h00, 0, 0, 0, o_fetch(0, 0), 1);
        step("to_err",    6'h02, 6'h00, 0, 0, 0, o_fetch(0, 1), 1);
        for (int i = 0; i < 15; i++)
            step("to_rewait", 6'h02, 6'h00, 0, 0, 0, o_fetch(0, 0), 1);
        step("to_late",   6'h02, 6'h00, 0, 0, 1, o_fetch(1, 0), 1);
        step("to_dec",    6'h02, 6'h00, 0, 0, 1, o_decode(0),   1);
        step("to_jump",   6'h02, 6'h00, 0, 0, 1, o_jump(),      1);
        step("to_fetch",  6'h02, 6'h00, 0, 0, 0, o_fetch(0, 0), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
